// File: rtl/sr_byte_xfer_ctrl.sv
// sr_byte_xfer_ctrl: loads a byte into an external 8-bit shift register, shifts it out while shifting rx_ser in, and returns the received byte
module sr_byte_xfer_ctrl #(
  parameter int NUM_BITS = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       msb_first,
  input  logic       rx_ser,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       bit_strobe,
  output logic [1:0] sr_ctrl,
  output logic [7:0] sr_par_in,
  output logic       sr_ser_in,
  input  logic [7:0] sr_par_out
);
  localparam int CW = $clog2(NUM_BITS) + 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [7:0] tx_lat;
  logic msb_lat;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      bit_strobe <= 1'b0;
      tx_lat     <= '0;
      msb_lat    <= 1'b1;
    end else begin
      state      <= state_nx;
      cnt        <= (state == SHIFT) ? cnt + 1'b1 : '0;
      rx_valid   <= (state == DONE);
      bit_strobe <= (state == SHIFT);
      if (state == IDLE && tx_valid) begin
        tx_lat  <= tx_data;
        msb_lat <= msb_first;
      end
      if (state == DONE) rx_data <= sr_par_out;
    end
  end
  always_comb begin
    state_nx  = (state == IDLE)  ? (tx_valid ? LOAD : IDLE) :
                (state == LOAD)  ? SHIFT :
                (state == SHIFT) ? ((cnt == LAST) ? DONE : SHIFT) : IDLE;
    tx_ready  = (state == IDLE);
    busy      = (state != IDLE);
    sr_ctrl   = (state == LOAD) ? 2'b11 : (state == SHIFT) ? (msb_lat ? 2'b01 : 2'b10) : 2'b00;
    sr_par_in = (state == LOAD) ? tx_lat : 8'h00;
    sr_ser_in = (state == SHIFT) && rx_ser;
  end
endmodule

// File: tb/tb_sr_byte_xfer_ctrl.sv
// tb_sr_byte_xfer_ctrl: randomized self-checking bench with a shift-register model and a spec-level byte-exchange reference
module tb_sr_byte_xfer_ctrl;
  logic clk = 1'b0;
  logic rstn, tx_valid, tx_ready, msb_first, rx_ser, rx_valid, busy, bit_strobe, sr_ser_in;
  logic [7:0] tx_data, rx_data, sr_par_in, sr_par_out;
  logic [1:0] sr_ctrl;
  logic reg_ser_out;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  sr_byte_xfer_ctrl #(.NUM_BITS(8)) dut (
    .clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .msb_first(msb_first), .rx_ser(rx_ser), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .bit_strobe(bit_strobe), .sr_ctrl(sr_ctrl), .sr_par_in(sr_par_in),
    .sr_ser_in(sr_ser_in), .sr_par_out(sr_par_out)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_par_out  <= '0;
      reg_ser_out <= 1'b0;
    end else begin
      case (sr_ctrl)
        2'b01: {reg_ser_out, sr_par_out} <= {sr_par_out, sr_ser_in};
        2'b10: {sr_par_out, reg_ser_out} <= {sr_ser_in, sr_par_out};
        2'b11: sr_par_out <= sr_par_in;
        default: ;
      endcase
    end
  end
  task automatic test_reset;
    rstn = 1'b0; tx_valid = 1'b0; tx_data = 8'h5A; msb_first = 1'b0; rx_ser = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b exp 1", tx_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (sr_ctrl !== 2'b00) begin errors++; $display("FAIL reset_sr_ctrl got %b exp 00", sr_ctrl); end
    checks++; if (sr_par_in !== 8'h00) begin errors++; $display("FAIL reset_sr_par_in got %h exp 00", sr_par_in); end
    checks++; if (sr_ser_in !== 1'b0) begin errors++; $display("FAIL reset_sr_ser_in got %b exp 0", sr_ser_in); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
    checks++; if (rx_valid !== 1'b0 || bit_strobe !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b exp 00", rx_valid, bit_strobe); end
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset got ready=%b busy=%b exp 1 0", tx_ready, busy); end
  endtask
  task automatic do_xfer(input logic [7:0] tx, input logic msb, input logic [7:0] rx_seq, input bit change_cfg, input bit poke_busy);
    logic [7:0] exp_rx;
    logic exp_bit;
    for (int i = 0; i < 8; i++) exp_rx[msb ? 7 - i : i] = rx_seq[7 - i];
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL xfer_start_ready got %b exp 1", tx_ready); end
    tx_data = tx; msb_first = msb; tx_valid = 1'b1; rx_ser = $urandom;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    if (change_cfg) begin tx_data = ~tx; msb_first = ~msb; end
    checks++; if (sr_ctrl !== 2'b11 || sr_par_in !== tx || busy !== 1'b1 || tx_ready !== 1'b0) begin errors++; $display("FAIL load_cycle got ctrl=%b par=%h busy=%b ready=%b exp 11 %h 1 0", sr_ctrl, sr_par_in, busy, tx_ready, tx); end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rx_ser = rx_seq[7 - i];
      if (poke_busy && i == 3) tx_valid = 1'b1;
      #1;
      checks++; if (sr_ctrl !== (msb ? 2'b01 : 2'b10) || busy !== 1'b1 || tx_ready !== 1'b0) begin errors++; $display("FAIL shift_ctrl[%0d] got ctrl=%b busy=%b ready=%b exp %b 1 0", i, sr_ctrl, busy, tx_ready, msb ? 2'b01 : 2'b10); end
      checks++; if (sr_ser_in !== rx_ser) begin errors++; $display("FAIL ser_in_pass[%0d] got %b exp %b", i, sr_ser_in, rx_ser); end
      @(posedge clk); #1;
      tx_valid = 1'b0;
      exp_bit = msb ? tx[7 - i] : tx[i];
      checks++; if (bit_strobe !== 1'b1 || reg_ser_out !== exp_bit) begin errors++; $display("FAIL tx_bit[%0d] got strobe=%b bit=%b exp 1 %b", i, bit_strobe, reg_ser_out, exp_bit); end
    end
    checks++; if (sr_ctrl !== 2'b00 || busy !== 1'b1 || rx_valid !== 1'b0) begin errors++; $display("FAIL done_cycle got ctrl=%b busy=%b rxv=%b exp 00 1 0", sr_ctrl, busy, rx_valid); end
    @(posedge clk); #1;
    checks++; if (rx_valid !== 1'b1 || rx_data !== exp_rx) begin errors++; $display("FAIL rx_byte got valid=%b data=%h exp 1 %h", rx_valid, rx_data, exp_rx); end
    checks++; if (busy !== 1'b0 || tx_ready !== 1'b1 || bit_strobe !== 1'b0) begin errors++; $display("FAIL back_to_idle got busy=%b ready=%b strobe=%b exp 0 1 0", busy, tx_ready, bit_strobe); end
    @(posedge clk); #1;
    checks++; if (rx_valid !== 1'b0 || rx_data !== exp_rx) begin errors++; $display("FAIL rx_pulse_end got valid=%b data=%h exp 0 %h", rx_valid, rx_data, exp_rx); end
  endtask
  task automatic test_msb_first;
    do_xfer(8'hA5, 1'b1, 8'b11001010, 1'b0, 1'b0);
  endtask
  task automatic test_lsb_first;
    do_xfer(8'h01, 1'b0, 8'hFF, 1'b0, 1'b0);
  endtask
  task automatic test_cfg_change;
    do_xfer(8'h3C, 1'b1, 8'($urandom), 1'b1, 1'b0);
  endtask
  task automatic test_random;
    for (int k = 0; k < 10; k++) do_xfer(8'($urandom), 1'($urandom), 8'($urandom), 1'b0, 1'b0);
  endtask
  task automatic test_busy_ignore;
    int extra = 0;
    do_xfer(8'($urandom), 1'($urandom), 8'($urandom), 1'b0, 1'b1);
    for (int c = 0; c < 15; c++) begin
      if (rx_valid || busy) extra++;
      @(posedge clk); #1;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL busy_poke_extra got %0d active cycles exp 0", extra); end
  endtask
  task automatic test_reset_mid;
    int seen = 0;
    tx_data = 8'($urandom); msb_first = 1'($urandom); tx_valid = 1'b1; rx_ser = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || sr_ctrl !== 2'b00 || tx_ready !== 1'b1) begin errors++; $display("FAIL mid_reset got busy=%b ctrl=%b ready=%b exp 0 00 1", busy, sr_ctrl, tx_ready); end
    checks++; if (rx_data !== 8'h00 || bit_strobe !== 1'b0) begin errors++; $display("FAIL mid_reset_data got %h strobe=%b exp 00 0", rx_data, bit_strobe); end
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (rx_valid) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0 || rx_data !== 8'h00) begin errors++; $display("FAIL no_rx_after_reset got pulses=%0d data=%h exp 0 00", seen, rx_data); end
    do_xfer(8'($urandom), 1'($urandom), 8'($urandom), 1'b0, 1'b0);
  endtask
  task automatic test_back_to_back;
    logic [7:0] bytes [3];
    int acc [3];
    logic rxs [64];
    logic q [$];
    int nacc = 0, nrx = 0, nlow = 0;
    logic m;
    logic [7:0] exp_rx;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    m = 1'($urandom);
    msb_first = m; tx_data = bytes[0]; tx_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && nrx < 3; cyc++) begin
      rx_ser = 1'($urandom);
      rxs[cyc + 1] = rx_ser;
      if (tx_valid && tx_ready) begin acc[nacc] = cyc + 1; nacc++; end
      @(posedge clk); #1;
      if (nacc > 0 && acc[nacc - 1] == cyc + 1) begin
        tx_valid = (nacc < 3);
        tx_data = (nacc < 3) ? bytes[nacc] : 8'h00;
      end
      if (!tx_ready) nlow++;
      if (bit_strobe) q.push_back(reg_ser_out);
      if (rx_valid) begin
        if (nrx < nacc) begin
          for (int i = 0; i < 8; i++) exp_rx[m ? 7 - i : i] = rxs[acc[nrx] + 2 + i];
          checks++; if (cyc + 1 !== acc[nrx] + 10) begin errors++; $display("FAIL b2b_rx_time[%0d] got edge %0d exp %0d", nrx, cyc + 1, acc[nrx] + 10); end
          checks++; if (rx_data !== exp_rx) begin errors++; $display("FAIL b2b_rx_data[%0d] got %h exp %h", nrx, rx_data, exp_rx); end
        end else begin
          checks++; errors++; $display("FAIL b2b_rx_unexpected got pulse %0d exp none", nrx);
        end
        nrx++;
      end
    end
    tx_valid = 1'b0;
    checks++; if (nacc !== 3 || nrx !== 3) begin errors++; $display("FAIL b2b_counts got acc=%0d rx=%0d exp 3 3", nacc, nrx); end
    if (nacc == 3) begin
      checks++; if (acc[1] - acc[0] !== 11 || acc[2] - acc[1] !== 11) begin errors++; $display("FAIL b2b_spacing got %0d %0d exp 11 11", acc[1] - acc[0], acc[2] - acc[1]); end
    end
    checks++; if (nlow !== 30) begin errors++; $display("FAIL b2b_ready_low got %0d exp 30", nlow); end
    checks++; if (q.size() !== 24) begin errors++; $display("FAIL b2b_bit_count got %0d exp 24", q.size()); end
    else for (int k = 0; k < 3; k++) for (int i = 0; i < 8; i++) begin
      checks++; if (q[8 * k + i] !== (m ? bytes[k][7 - i] : bytes[k][i])) begin errors++; $display("FAIL b2b_tx_bit[%0d][%0d] got %b exp %b", k, i, q[8 * k + i], m ? bytes[k][7 - i] : bytes[k][i]); end
    end
    @(posedge clk); #1;
  endtask
  initial begin
    test_reset;
    test_msb_first;
    test_lsb_first;
    test_cfg_change;
    test_random;
    test_busy_ignore;
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
